// File: rtl/cb_pkg.sv
// ---------------------------------------------------------------------------
// cb_pkg
// Shared definitions for the circular_buffer subsystem (reorder_tag_assigner,
// circular_buffer and their benches).
//   status_t  : 2-bit per-packet verdict status
//   PENDING   : no verdict yet (also the value of a free tag)
//   REJECTED  : a filter core rejected the packet
//   ACCEPTED  : a filter core accepted the packet
// ---------------------------------------------------------------------------
package cb_pkg;

  typedef logic [1:0] status_t;

  localparam status_t PENDING  = 2'b00;
  localparam status_t REJECTED = 2'b01;
  localparam status_t ACCEPTED = 2'b11;

endpackage

// File: rtl/tag_status_table.sv
// ---------------------------------------------------------------------------
// tag_status_table
// Per-tag verdict status storage for the reorder tag assigner.
//   clk, rst        : clock, synchronous active-high reset (all entries PENDING)
//   verdict_*       : filter verdict write (accept -> ACCEPTED, else REJECTED)
//   retire_*        : clear the retired tag back to PENDING
//   alloc_*         : clear a newly allocated tag to PENDING
//   lookup_tag      : tag being queried
//   lookup_status   : combinational status of lookup_tag (PENDING if out of range)
// Write priority, lowest to highest: verdict, retire, allocate.
// ---------------------------------------------------------------------------
module tag_status_table
  import cb_pkg::*;
#(
  parameter int SIZE      = 3,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 verdict_valid,
  input  logic [TAG_WIDTH-1:0] verdict_tag,
  input  logic                 verdict_accept,
  input  logic                 retire_valid,
  input  logic [TAG_WIDTH-1:0] retire_tag,
  input  logic                 alloc_valid,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output status_t              lookup_status
);

  status_t status_mem [SIZE];

  // NOTE: this table is a handful of flops whose reset value is architecturally
  // visible (every tag must read PENDING after reset), so it is reset like any
  // other state rather than left as an unreset RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) status_mem[i] <= PENDING;
    end else begin
      // Later assignments to the same entry win, which encodes the priority.
      for (int i = 0; i < SIZE; i++) begin
        if (verdict_valid && verdict_tag == TAG_WIDTH'(i))
          status_mem[i] <= verdict_accept ? ACCEPTED : REJECTED;
        if (retire_valid && retire_tag == TAG_WIDTH'(i))
          status_mem[i] <= PENDING;
        if (alloc_valid && alloc_tag == TAG_WIDTH'(i))
          status_mem[i] <= PENDING;
      end
    end
  end

  // Compare-based read avoids indexing a SIZE-entry array with a wider tag;
  // an out-of-range tag matches nothing and falls through to PENDING.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    lookup_status = PENDING;
    for (int i = 0; i < SIZE; i++) begin
      if (lookup_tag == TAG_WIDTH'(i)) lookup_status = status_mem[i];
    end
  end

endmodule

// File: rtl/reorder_tag_assigner.sv
// ---------------------------------------------------------------------------
// reorder_tag_assigner
// Stamps incoming AXI-Stream packets with a rotating reorder tag, forwards the
// beats through a one-entry output register, and owns the per-tag status table
// (filter verdicts, buffer lookup, retirement). Back-pressures new packets
// while every tag is in flight.
//   clk, rst                      : clock, synchronous active-high reset
//   in_T*                         : raw input stream
//   buffer_T*, reorder_tag_in     : tagged stream to circular_buffer
//   verdict_valid/tag/accept      : filter verdict write
//   reorder_tag_out/packet_status : buffer status lookup (combinational)
//   retire_valid                  : buffer retired its oldest packet
//   tag_error                     : sticky protocol error
// Build option: define REORDER_TAG_ERR_CHECK_EN to generate the protocol
// checker driving tag_error; otherwise tag_error is tied low.
// ---------------------------------------------------------------------------
module reorder_tag_assigner
  import cb_pkg::*;
#(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 3,
  parameter int DATA_WIDTH           = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_TDATA,
  input  logic                  in_TLAST,
  input  logic                  in_TVALID,
  output logic                  in_TREADY,
  output logic [DATA_WIDTH-1:0] buffer_TDATA,
  output logic [TAG_WIDTH-1:0]  reorder_tag_in,
  output logic                  buffer_TLAST,
  output logic                  buffer_TVALID,
  input  logic                  buffer_TREADY,
  input  logic                  verdict_valid,
  input  logic [TAG_WIDTH-1:0]  verdict_tag,
  input  logic                  verdict_accept,
  input  logic [TAG_WIDTH-1:0]  reorder_tag_out,
  output logic [1:0]            packet_status,
  input  logic                  retire_valid,
  output logic                  tag_error
);

  localparam int                   CW       = $clog2(CIRCULAR_BUFFER_SIZE + 1);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(CIRCULAR_BUFFER_SIZE);

  logic [TAG_WIDTH-1:0] next_tag;
  logic [TAG_WIDTH-1:0] oldest_tag;
  logic [TAG_WIDTH-1:0] pkt_tag;
  logic [TAG_WIDTH-1:0] beat_tag;
  logic [CW-1:0]        in_flight;
  logic                 mid_pkt;
  logic                 ready;
  logic                 accept;
  logic                 alloc;
  logic                 retire_ok;

  function automatic logic [TAG_WIDTH-1:0] tag_inc(input logic [TAG_WIDTH-1:0] t);
    return (t == LAST_TAG) ? '0 : t + 1'b1;
  endfunction

  // Only packet starts need a free tag; the full check uses the registered
  // count, so a retire in the same cycle opens the gate one cycle later.
  assign ready     = !rst && (!buffer_TVALID || buffer_TREADY)
                     && (mid_pkt || in_flight < FULL_CNT);
  assign in_TREADY = ready;
  assign accept    = in_TVALID && ready;
  assign alloc     = accept && !mid_pkt;
  assign retire_ok = retire_valid && (in_flight != '0);
  assign beat_tag  = mid_pkt ? pkt_tag : next_tag;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_TVALID  <= 1'b0;
      buffer_TDATA   <= '0;
      buffer_TLAST   <= 1'b0;
      reorder_tag_in <= '0;
      next_tag       <= '0;
      oldest_tag     <= '0;
      pkt_tag        <= '0;
      in_flight      <= '0;
      mid_pkt        <= 1'b0;
    end else begin
      if (accept) begin
        buffer_TVALID  <= 1'b1;
        buffer_TDATA   <= in_TDATA;
        buffer_TLAST   <= in_TLAST;
        reorder_tag_in <= beat_tag;
        mid_pkt        <= !in_TLAST;
      end else if (buffer_TREADY) begin
        buffer_TVALID <= 1'b0;
      end

      if (alloc) begin
        pkt_tag  <= next_tag;
        next_tag <= tag_inc(next_tag);
      end

      if (retire_ok) oldest_tag <= tag_inc(oldest_tag);

      case ({alloc, retire_ok})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  tag_status_table #(
    .SIZE      (CIRCULAR_BUFFER_SIZE),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_table (
    .clk            (clk),
    .rst            (rst),
    .verdict_valid  (verdict_valid),
    .verdict_tag    (verdict_tag),
    .verdict_accept (verdict_accept),
    .retire_valid   (retire_ok),
    .retire_tag     (oldest_tag),
    .alloc_valid    (alloc),
    .alloc_tag      (next_tag),
    .lookup_tag     (reorder_tag_out),
    .lookup_status  (packet_status)
  );

`ifdef REORDER_TAG_ERR_CHECK_EN
  logic verdict_live;
  logic err_event;
  logic tag_error_q;

  // A tag is live when its distance past oldest_tag (mod SIZE) is below the
  // in-flight count.
  always_comb begin
    verdict_live = 1'b0;
    for (int i = 0; i < CIRCULAR_BUFFER_SIZE; i++) begin
      if (verdict_tag == TAG_WIDTH'(i) &&
          ((i + CIRCULAR_BUFFER_SIZE - int'(oldest_tag)) % CIRCULAR_BUFFER_SIZE)
            < int'(in_flight))
        verdict_live = 1'b1;
    end
  end

  assign err_event = (retire_valid && in_flight == '0)
                   || (verdict_valid && (verdict_tag > LAST_TAG || !verdict_live));

  always_ff @(posedge clk) begin
    if (rst)            tag_error_q <= 1'b0;
    else if (err_event) tag_error_q <= 1'b1;
  end

  assign tag_error = tag_error_q;
`else
  assign tag_error = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_tag_assigner.sv
module tb_reorder_tag_assigner;
  import cb_pkg::*;

  localparam int TW = 6;
  localparam int SZ = 3;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_TDATA = '0;
  logic          in_TLAST = 1'b0;
  logic          in_TVALID = 1'b0;
  logic          in_TREADY;
  logic [DW-1:0] buffer_TDATA;
  logic [TW-1:0] reorder_tag_in;
  logic          buffer_TLAST;
  logic          buffer_TVALID;
  logic          buffer_TREADY = 1'b0;
  logic          verdict_valid = 1'b0;
  logic [TW-1:0] verdict_tag = '0;
  logic          verdict_accept = 1'b0;
  logic [TW-1:0] reorder_tag_out = '0;
  logic [1:0]    packet_status;
  logic          retire_valid = 1'b0;
  logic          tag_error;

  always #5 clk = ~clk;

  reorder_tag_assigner #(
    .TAG_WIDTH            (TW),
    .CIRCULAR_BUFFER_SIZE (SZ),
    .DATA_WIDTH           (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_TDATA        (in_TDATA),
    .in_TLAST        (in_TLAST),
    .in_TVALID       (in_TVALID),
    .in_TREADY       (in_TREADY),
    .buffer_TDATA    (buffer_TDATA),
    .reorder_tag_in  (reorder_tag_in),
    .buffer_TLAST    (buffer_TLAST),
    .buffer_TVALID   (buffer_TVALID),
    .buffer_TREADY   (buffer_TREADY),
    .verdict_valid   (verdict_valid),
    .verdict_tag     (verdict_tag),
    .verdict_accept  (verdict_accept),
    .reorder_tag_out (reorder_tag_out),
    .packet_status   (packet_status),
    .retire_valid    (retire_valid),
    .tag_error       (tag_error)
  );

`ifdef REORDER_TAG_ERR_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    int            tag;
    logic          last;
  } beat_t;

  beat_t   outq[$];     // beats accepted but not yet taken by the buffer
  int      live_q[$];   // in-flight tags, oldest first
  status_t st_m [SZ];
  int      next_m;
  int      cur_m;
  bit      mid_m;
  bit      err_m;
  bit      exp_ready;

  task automatic model_reset();
    outq.delete();
    live_q.delete();
    for (int i = 0; i < SZ; i++) st_m[i] = PENDING;
    next_m = 0;
    cur_m  = 0;
    mid_m  = 1'b0;
    err_m  = 1'b0;
  endtask

  function automatic bit is_live(input int t);
    foreach (live_q[i]) if (live_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Called at the falling edge: compare every output with the model.
  task automatic sample_and_check();
    exp_ready = !rst && (outq.size() == 0 || buffer_TREADY) && (mid_m || live_q.size() < SZ);
    check("in_tready", 64'(in_TREADY), 64'(exp_ready));
    check("buffer_tvalid", 64'(buffer_TVALID), 64'(outq.size() != 0));
    if (outq.size() != 0) begin
      check("buffer_tdata", buffer_TDATA, outq[0].d);
      check("reorder_tag_in", 64'(reorder_tag_in), 64'(outq[0].tag));
      check("buffer_tlast", 64'(buffer_TLAST), 64'(outq[0].last));
    end
    check("packet_status", 64'(packet_status),
          64'((int'(reorder_tag_out) < SZ) ? st_m[int'(reorder_tag_out)] : PENDING));
    check("tag_error", 64'(tag_error), 64'(err_m));
  endtask

  // Advance one clock and apply the rules to the model.
  task automatic advance();
    int t;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ERR_ON) begin
        if (retire_valid && live_q.size() == 0) err_m = 1'b1;
        if (verdict_valid && (int'(verdict_tag) >= SZ || !is_live(int'(verdict_tag))))
          err_m = 1'b1;
      end
      if (outq.size() != 0 && buffer_TREADY) void'(outq.pop_front());
      if (verdict_valid && int'(verdict_tag) < SZ)
        st_m[int'(verdict_tag)] = verdict_accept ? ACCEPTED : REJECTED;
      if (retire_valid && live_q.size() != 0) begin
        st_m[live_q[0]] = PENDING;
        void'(live_q.pop_front());
      end
      if (in_TVALID && exp_ready) begin
        if (!mid_m) begin
          cur_m  = next_m;
          next_m = (next_m + 1) % SZ;
          live_q.push_back(cur_m);
          st_m[cur_m] = PENDING;
        end
        t = cur_m;
        outq.push_back('{d: in_TDATA, tag: t, last: in_TLAST});
        mid_m = !in_TLAST;
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    in_TVALID       = 1'b0;
    in_TLAST        = 1'b0;
    in_TDATA        = '0;
    buffer_TREADY   = 1'b1;
    verdict_valid   = 1'b0;
    verdict_tag     = '0;
    verdict_accept  = 1'b0;
    reorder_tag_out = '0;
    retire_valid    = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("in_tready_in_reset", 64'(in_TREADY), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_tvalid", 64'(buffer_TVALID), 64'(0));
    check("rst_tlast", 64'(buffer_TLAST), 64'(0));
    check("rst_tdata", buffer_TDATA, 64'(0));
    check("rst_tag", 64'(reorder_tag_in), 64'(0));
    check("rst_tready", 64'(in_TREADY), 64'(1));
    check("rst_tag_error", 64'(tag_error), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          v, l;
    logic [DW-1:0] d;
    logic          br, vv;
    int            vt;
    logic          va;
    int            lt;
    logic          ret;
    logic          er, ebv;
    int            etag;
    logic          elast, cs;
    logic [1:0]    est;
  } vec_t;

  function automatic vec_t mk(input logic v, l, input logic [DW-1:0] d, input logic br,
                              input logic vv, input int vt, input logic va, input int lt,
                              input logic ret, input logic er, ebv, input int etag,
                              input logic elast, cs, input logic [1:0] est);
    return '{v: v, l: l, d: d, br: br, vv: vv, vt: vt, va: va, lt: lt, ret: ret,
             er: er, ebv: ebv, etag: etag, elast: elast, cs: cs, est: est};
  endfunction

  vec_t vecs [22];

  initial begin
    //             v  l  data    br vv vt va lt ret  er ebv tag last cs est
    vecs[0]  = mk(1, 0, 64'hA0, 1, 0, 0, 0, 0, 0,   1, 0,  0,  0,   0, 0);
    vecs[1]  = mk(1, 0, 64'hA1, 1, 0, 0, 0, 0, 0,   1, 1,  0,  0,   0, 0);
    vecs[2]  = mk(1, 1, 64'hA2, 1, 0, 0, 0, 0, 0,   1, 1,  0,  0,   0, 0);
    vecs[3]  = mk(1, 1, 64'hB0, 1, 0, 0, 0, 0, 0,   1, 1,  0,  1,   0, 0);
    vecs[4]  = mk(1, 1, 64'hC0, 1, 0, 0, 0, 0, 0,   1, 1,  1,  1,   0, 0);
    vecs[5]  = mk(1, 1, 64'hD0, 1, 1, 1, 1, 0, 0,   0, 1,  2,  1,   0, 0);
    vecs[6]  = mk(1, 1, 64'hD0, 1, 0, 0, 0, 1, 1,   0, 0,  0,  0,   1, ACCEPTED);
    vecs[7]  = mk(1, 1, 64'hD0, 1, 0, 0, 0, 1, 0,   1, 0,  0,  0,   1, ACCEPTED);
    vecs[8]  = mk(0, 0, 64'h0,  1, 0, 0, 0, 1, 1,   0, 1,  0,  1,   1, ACCEPTED);
    vecs[9]  = mk(1, 1, 64'hE0, 1, 0, 0, 0, 1, 0,   1, 0,  0,  0,   1, PENDING);
    vecs[10] = mk(1, 1, 64'hF0, 1, 0, 0, 0, 0, 1,   0, 1,  1,  1,   0, 0);
    vecs[11] = mk(1, 1, 64'hF0, 1, 0, 0, 0, 0, 1,   1, 0,  0,  0,   0, 0);
    vecs[12] = mk(0, 0, 64'h0,  1, 0, 0, 0, 0, 0,   1, 1,  2,  1,   0, 0);
    vecs[13] = mk(1, 0, 64'h60, 1, 0, 0, 0, 0, 0,   1, 0,  0,  0,   0, 0);
    for (int i = 14; i <= 18; i++)
      vecs[i] = mk(1, 0, 64'h61, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 64'h61, 1, 0, 0, 0, 0, 0,   1, 1,  0,  0,   0, 0);
    vecs[20] = mk(1, 1, 64'h62, 1, 0, 0, 0, 0, 0,   1, 1,  0,  0,   0, 0);
    vecs[21] = mk(0, 0, 64'h0,  1, 0, 0, 0, 0, 0,   0, 1,  0,  1,   0, 0);
  end

  initial begin
    model_reset();
    do_reset();

    // Directed scenarios: multi-beat packet, tag wrap with back-pressure,
    // verdict/lookup/retire, retire at full, output stall.
    foreach (vecs[i]) begin
      in_TVALID       = vecs[i].v;
      in_TLAST        = vecs[i].l;
      in_TDATA        = vecs[i].d;
      buffer_TREADY   = vecs[i].br;
      verdict_valid   = vecs[i].vv;
      verdict_tag     = TW'(vecs[i].vt);
      verdict_accept  = vecs[i].va;
      reorder_tag_out = TW'(vecs[i].lt);
      retire_valid    = vecs[i].ret;
      @(negedge clk);
      check($sformatf("vec%0d_tready", i), 64'(in_TREADY), 64'(vecs[i].er));
      check($sformatf("vec%0d_tvalid", i), 64'(buffer_TVALID), 64'(vecs[i].ebv));
      if (vecs[i].ebv) begin
        check($sformatf("vec%0d_tag", i), 64'(reorder_tag_in), 64'(vecs[i].etag));
        check($sformatf("vec%0d_tlast", i), 64'(buffer_TLAST), 64'(vecs[i].elast));
      end
      if (vecs[i].cs)
        check($sformatf("vec%0d_status", i), 64'(packet_status), 64'(vecs[i].est));
      sample_and_check();
      advance();
    end

    // Retire with nothing in flight: sticky error only when the checker is built.
    do_reset();
    retire_valid = 1'b1;
    @(negedge clk);
    sample_and_check();
    advance();
    retire_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tag_error_sticky", 64'(tag_error), 64'(ERR_ON));
      sample_and_check();
      advance();
    end
    do_reset();
    check("tag_error_cleared", 64'(tag_error), 64'(0));

    // Randomised traffic against the model, with occasional mid-stream resets.
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 99) == 0);
      in_TVALID       = ($urandom_range(0, 3) != 0);
      in_TLAST        = ($urandom_range(0, 2) == 0);
      in_TDATA        = {$urandom, $urandom};
      buffer_TREADY   = ($urandom_range(0, 3) != 0);
      verdict_valid   = ($urandom_range(0, 3) == 0);
      verdict_tag     = ($urandom_range(0, 9) == 0) ? TW'($urandom_range(3, 63))
                                                    : TW'($urandom_range(0, 2));
      verdict_accept  = $urandom_range(0, 1) == 1;
      reorder_tag_out = TW'($urandom_range(0, 4));
      retire_valid    = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      sample_and_check();
      advance();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
